// File: rtl/dac_seg_pkg.sv
// Shared constants and types for the segmented DAC code encoder.
// Optional feature macro DAC_SEG_DEM_EN is consumed by the encoder files, not here.
package dac_seg_pkg;

    localparam int BIN_W      = 7;
    localparam int THERM_W    = 17;
    localparam int TCOUNT_W   = 5;
    localparam int FULL_SCALE = THERM_W * (1 << BIN_W) + (1 << BIN_W) - 1;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        ACTIVE = 2'd2
    } fsm_state_t;

    typedef logic [THERM_W-1:0] therm_t;

endpackage

// File: rtl/dac_seg_therm_enc.sv
// Combinational count-to-unary mapping for the MSB segment.
// With DAC_SEG_DEM_EN defined, the unary run starts at ptr and wraps modulo THERM_W.
module dac_seg_therm_enc
    import dac_seg_pkg::*;
(
    input  logic [TCOUNT_W-1:0] tcount,
`ifdef DAC_SEG_DEM_EN
    input  logic [TCOUNT_W-1:0] ptr,
`endif
    output therm_t              therm
);

    genvar gi;
    generate
        for (gi = 0; gi < THERM_W; gi++) begin : g_bit
`ifdef DAC_SEG_DEM_EN
            logic [5:0] diff;
            logic [5:0] rel;
            // (gi - ptr) mod THERM_W, kept non-negative by adding THERM_W first
            assign diff      = 6'(gi + THERM_W) - {1'b0, ptr};
            assign rel       = (diff >= 6'(THERM_W)) ? diff - 6'(THERM_W) : diff;
            assign therm[gi] = rel < {1'b0, tcount};
`else
            assign therm[gi] = 5'(gi) < tcount;
`endif
        end
    endgenerate

endmodule

// File: rtl/dac_seg_encoder.sv
// Segmented DAC encoder: power FSM, 2-stage code pipeline, binary/unary outputs with complements.
// Define DAC_SEG_DEM_EN to enable data-weighted averaging of the unary segment.
module dac_seg_encoder
    import dac_seg_pkg::*;
#(
    parameter int CODE_W        = 12,
    parameter int WARMUP_CYCLES = 16
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic              pdb,
    output logic [BIN_W-1:0]  datainbin,
    output logic [BIN_W-1:0]  datainbinb,
    output therm_t            dataintherm,
    output therm_t            datainthermb,
    output logic              sat
);

    fsm_state_t state_reg, state_next;
    logic [7:0] warm_cnt_reg, warm_cnt_next;
    logic       pdb_reg;

    always_comb begin
        state_next    = state_reg;
        warm_cnt_next = warm_cnt_reg;
        case (state_reg)
            OFF: begin
                if (en) begin
                    state_next    = WARMUP;
                    warm_cnt_next = '0;
                end
            end
            WARMUP: begin
                if (warm_cnt_reg == 8'(WARMUP_CYCLES - 1))
                    state_next = ACTIVE;
                else
                    warm_cnt_next = warm_cnt_reg + 8'd1;
            end
            ACTIVE:  state_next = ACTIVE;
            default: state_next = OFF;
        endcase
        // Power-down wins from any state
        if (!en)
            state_next = OFF;
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_reg    <= OFF;
            warm_cnt_reg <= '0;
            pdb_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            warm_cnt_reg <= warm_cnt_next;
            pdb_reg      <= (state_next != OFF);
        end
    end

    assign code_ready = (state_reg == ACTIVE);
    assign pdb        = pdb_reg;

    logic accept;
    assign accept = code_valid && code_ready;

    logic [31:0]         code_ext;
    logic                over_fs;
    logic [BIN_W-1:0]    bin_in;
    logic [TCOUNT_W-1:0] tcount_in;

    assign code_ext  = 32'(code);
    assign over_fs   = code_ext > 32'(FULL_SCALE);
    assign bin_in    = over_fs ? '1 : code_ext[BIN_W-1:0];
    assign tcount_in = over_fs ? TCOUNT_W'(THERM_W) : code_ext[BIN_W +: TCOUNT_W];

    logic                s1_valid_reg;
    logic [BIN_W-1:0]    s1_bin_reg;
    logic [TCOUNT_W-1:0] s1_tcount_reg;
    logic                s1_sat_reg;

    // A code accepted on the en-falling edge is consumed but never enters the pipe
    always_ff @(posedge clkin) begin
        if (rst) begin
            s1_valid_reg  <= 1'b0;
            s1_bin_reg    <= '0;
            s1_tcount_reg <= '0;
            s1_sat_reg    <= 1'b0;
        end else begin
            s1_valid_reg <= accept && en;
            if (accept) begin
                s1_bin_reg    <= bin_in;
                s1_tcount_reg <= tcount_in;
                s1_sat_reg    <= over_fs;
            end
        end
    end

    therm_t therm_next;

`ifdef DAC_SEG_DEM_EN
    logic [TCOUNT_W-1:0] ptr_reg, ptr_next, s1_ptr_reg, tcount_mod;
    logic [5:0]          ptr_sum;

    assign tcount_mod = (tcount_in == TCOUNT_W'(THERM_W)) ? '0 : tcount_in;
    assign ptr_sum    = {1'b0, ptr_reg} + {1'b0, tcount_mod};
    assign ptr_next   = (ptr_sum >= 6'(THERM_W)) ? TCOUNT_W'(ptr_sum - 6'(THERM_W))
                                                 : ptr_sum[TCOUNT_W-1:0];

    // Each code is rotated by the pointer value current at its acceptance
    always_ff @(posedge clkin) begin
        if (rst) begin
            ptr_reg    <= '0;
            s1_ptr_reg <= '0;
        end else if (!en) begin
            ptr_reg    <= '0;
        end else if (accept) begin
            ptr_reg    <= ptr_next;
            s1_ptr_reg <= ptr_reg;
        end
    end

    dac_seg_therm_enc u_therm_enc (
        .tcount (s1_tcount_reg),
        .ptr    (s1_ptr_reg),
        .therm  (therm_next)
    );
`else
    dac_seg_therm_enc u_therm_enc (
        .tcount (s1_tcount_reg),
        .therm  (therm_next)
    );
`endif

    logic [BIN_W-1:0] bin_reg, binb_reg;
    therm_t           therm_reg, thermb_reg;
    logic             sat_reg;

    // True and complement rails come from twin registers of the same stage
    always_ff @(posedge clkin) begin
        if (rst || state_reg == OFF) begin
            bin_reg    <= '0;
            binb_reg   <= '1;
            therm_reg  <= '0;
            thermb_reg <= '1;
            sat_reg    <= 1'b0;
        end else if (s1_valid_reg && en) begin
            bin_reg    <= s1_bin_reg;
            binb_reg   <= ~s1_bin_reg;
            therm_reg  <= therm_next;
            thermb_reg <= ~therm_next;
            sat_reg    <= s1_sat_reg;
        end
    end

    assign datainbin    = bin_reg;
    assign datainbinb   = binb_reg;
    assign dataintherm  = therm_reg;
    assign datainthermb = thermb_reg;
    assign sat          = sat_reg;

endmodule
